watch_time_ctrl: RTL and testbench
==================================

// Module: watch_time_ctrl
// PURPOSE
//  Timekeeping and set-mode controller for the character-LCD watch.
//  Keeps HH:MM:SS in BCD, generates the 1 s tick from CLK, and runs a RUN/SET mode FSM from three buttons.
//  Drives the six BCD digits and per-field blank flags consumed by the LCD display driver.
//  Sits between the button debouncers and the LCD driver, on the same CLK as the driver.
// PARAMETERS
//  TICKS_PER_SEC  1000  CLK cycles per second; the prescaler wraps at TICKS_PER_SEC-1.
//  BLINK_TICKS    250   CLK cycles per blink half-period of the selected field in SET mode.
// PORTS
//  CLK       in   1  system clock; also the LCD driver clock.
//  RESETN    in   1  synchronous, active-low reset.
//  BTN_MODE  in   1  debounced level, active-high; enter/leave SET mode.
//  BTN_NEXT  in   1  debounced level, active-high; select next field in SET mode.
//  BTN_UP    in   1  debounced level, active-high; increment selected field in SET mode.
//  H10,H1    out  4  hour digits, BCD, 00..23.
//  M10,M1    out  4  minute digits, BCD, 00..59.
//  S10,S1    out  4  second digits, BCD, 00..59.
//  SET_MODE  out  1  1 while in any SET state.
//  SEL_FIELD out  2  0=none(RUN), 1=hour, 2=min, 3=sec.
//  BLANK_H/BLANK_M/BLANK_S out 1 each  display driver shows spaces for that field while high.
//  SEC_PULSE out  1  one-cycle pulse when RUN time advances one second.
// BEHAVIOUR
//  Reset (RESETN=0 at a CLK edge): time 00:00:00; state RUN; SET_MODE=0; SEL_FIELD=0; all BLANK_*=0.
//   Also on reset: SEC_PULSE=0, prescaler=0, blink counter=0, blink phase=on, button history=0.
//  Reset mid-operation overrides everything, including a button edge in the same cycle.
//  Buttons: rising edge = BTN & ~BTN_prev, with BTN_prev registered. Holding a button gives exactly one action.
//   Simultaneous edges: MODE > NEXT > UP. Only the highest-priority edge acts; the others are dropped.
//  FSM: RUN, SET_H, SET_M, SET_S.
//   RUN  --MODE--> SET_H.
//   SET_H --NEXT--> SET_M --NEXT--> SET_S --NEXT--> SET_H.
//   Any SET state --MODE--> RUN. Prescaler clears to 0 on entry to RUN, so the first tick comes TICKS_PER_SEC cycles later.
//   NEXT and UP in RUN are ignored.
//  Prescaler: counts only in RUN, 0..TICKS_PER_SEC-1.
//   At terminal count: seconds increment and SEC_PULSE=1, both registered in the following cycle.
//   Carry chain: S 59->00 carries to M; M 59->00 carries to H; H 23->00. 23:59:59 -> 00:00:00 in a single update.
//  SET states: time is frozen and the prescaler holds at 0.
//   UP increments the selected field only: H 23->00, M 59->00, S 59->00. No carry into other fields.
//   Edge sampled at cycle n; new digits are visible at n+1.
//  Blink: in SET states a counter toggles the blink phase every BLINK_TICKS cycles.
//   BLANK_x = (field x selected) & phase off. Phase resets to on at every SET entry and on every UP/NEXT action, so the edited field shows at once.
//   In RUN all BLANK_* are 0.
//  All outputs are registered. Digits are always valid BCD; no code above 9 is ever emitted.
// STRUCTURE
//  Package watch_pkg: FSM state encoding, SEL_FIELD codes, BCD limits (HOUR_MAX=8'h23, MINSEC_MAX=8'h59).
//  Sub-module bcd2_counter, instantiated 3x.
//   Two-digit BCD counter with MAX input, INC, CLR; outputs TENS/ONES and CARRY (INC at MAX).
//   Controller logic: INC = tick/carry in RUN, UP in SET; carry is gated off in SET.
//  Top level holds button edge logic, FSM, prescaler and blink generator.
// TESTING (TICKS_PER_SEC=4, BLINK_TICKS=2)
//  Reset, run 4*60 cycles -> 00:01:00; SEC_PULSE count = 60, each one cycle wide.
//  Preload 23:59:59 via SET, return to RUN, wait 4 cycles -> 00:00:00 on one edge; SEC_PULSE=1.
//  SET_M at M=59, press UP -> M=00, H unchanged; UP held 10 cycles -> only one increment.
//  MODE, NEXT and UP rise in the same cycle in RUN -> SET_H entered; H unchanged.
//  SET_S: observe BLANK_S toggling every 2 cycles; UP resets phase so BLANK_S=0 the next cycle; BLANK_H=BLANK_M=0 throughout.
//  RESETN=0 for 1 cycle during SET_M at 12:34:56 -> 00:00:00, RUN, all flags 0 on the next cycle.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared encodings for the watch timekeeping controller: FSM states, field-select codes
// and BCD limits used by the field counters.
package watch_pkg;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_HOUR = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;
  localparam logic [1:0] SEL_SEC  = 2'd3;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  // State codes double as the SEL_FIELD value, so the state register drives that output directly.
  typedef enum logic [1:0] {
    ST_RUN   = SEL_NONE,
    ST_SET_H = SEL_HOUR,
    ST_SET_M = SEL_MIN,
    ST_SET_S = SEL_SEC
  } state_e;

  // Blank mask {H, M, S} for the field edited in a given state.
  function automatic logic [2:0] field_mask(input state_e s);
    case (s)
      ST_SET_H: return 3'b100;
      ST_SET_M: return 3'b010;
      ST_SET_S: return 3'b001;
      default:  return 3'b000;
    endcase
  endfunction

  function automatic state_e next_field(input state_e s);
    case (s)
      ST_SET_H: return ST_SET_M;
      ST_SET_M: return ST_SET_S;
      default:  return ST_SET_H;
    endcase
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter wrapping from i_max to 00; o_carry flags an increment taken at i_max.
module bcd2_counter (
  input  logic       CLK,
  input  logic       i_clr,
  input  logic       i_inc,
  input  logic [7:0] i_max,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic       o_carry
);

  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       w_at_max;

  assign w_at_max = ({r_tens, r_ones} == i_max);
  assign o_carry  = i_inc & w_at_max;
  assign o_tens   = r_tens;
  assign o_ones   = r_ones;

  // NOTE: state updates use <= so every register samples pre-edge values, as the flops do.
  always_ff @(posedge CLK) begin
    if (i_clr) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (i_inc) begin
      if (w_at_max) begin
        r_tens <= 4'd0;
        r_ones <= 4'd0;
      end else if (r_ones == 4'd9) begin
        r_ones <= 4'd0;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/watch_time_ctrl.sv
// Watch timekeeping core: 1 s prescaler, HH:MM:SS BCD counters, RUN/SET mode FSM driven by
// three button edges, and the blink generator for the field being edited.
module watch_time_ctrl
  import watch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000,
  parameter int BLINK_TICKS   = 250
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       BTN_MODE,
  input  logic       BTN_NEXT,
  input  logic       BTN_UP,
  output logic [3:0] H10,
  output logic [3:0] H1,
  output logic [3:0] M10,
  output logic [3:0] M1,
  output logic [3:0] S10,
  output logic [3:0] S1,
  output logic       SET_MODE,
  output logic [1:0] SEL_FIELD,
  output logic       BLANK_H,
  output logic       BLANK_M,
  output logic       BLANK_S,
  output logic       SEC_PULSE
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  state_e        r_state;
  logic [2:0]    r_btn_prev;
  logic [PW-1:0] r_presc;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase_on;
  logic          r_set_mode;
  logic          r_sec_pulse;
  logic [2:0]    r_blank;

  logic [2:0] w_edge;
  logic       w_mode, w_next, w_up;
  logic       w_run, w_tick, w_clr;
  logic       w_inc_s, w_inc_m, w_inc_h;
  logic       w_carry_s, w_carry_m;

  // Only the highest-priority edge acts: MODE > NEXT > UP.
  assign w_edge = {BTN_MODE, BTN_NEXT, BTN_UP} & ~r_btn_prev;
  assign w_mode = w_edge[2];
  assign w_next = w_edge[1] & ~w_edge[2];
  assign w_up   = w_edge[0] & ~(|w_edge[2:1]);

  assign w_run  = (r_state == ST_RUN);
  assign w_tick = w_run & (r_presc == PRESC_LAST);
  assign w_clr  = ~RESETN;

  // RUN ripples the carry chain; SET bumps only the selected field with carries dropped.
  assign w_inc_s = w_run ? w_tick    : ((r_state == ST_SET_S) & w_up);
  assign w_inc_m = w_run ? w_carry_s : ((r_state == ST_SET_M) & w_up);
  assign w_inc_h = w_run ? w_carry_m : ((r_state == ST_SET_H) & w_up);

  bcd2_counter u_sec (
    .CLK(CLK), .i_clr(w_clr), .i_inc(w_inc_s), .i_max(MINSEC_MAX),
    .o_tens(S10), .o_ones(S1), .o_carry(w_carry_s)
  );

  bcd2_counter u_min (
    .CLK(CLK), .i_clr(w_clr), .i_inc(w_inc_m), .i_max(MINSEC_MAX),
    .o_tens(M10), .o_ones(M1), .o_carry(w_carry_m)
  );

  bcd2_counter u_hour (
    .CLK(CLK), .i_clr(w_clr), .i_inc(w_inc_h), .i_max(HOUR_MAX),
    .o_tens(H10), .o_ones(H1), .o_carry()
  );

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_btn_prev  <= 3'b000;
      r_sec_pulse <= 1'b0;
    end else begin
      r_btn_prev  <= {BTN_MODE, BTN_NEXT, BTN_UP};
      r_sec_pulse <= w_tick;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state     <= ST_RUN;
      r_set_mode  <= 1'b0;
      r_presc     <= '0;
      r_blink_cnt <= '0;
      r_phase_on  <= 1'b1;
      r_blank     <= 3'b000;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_blank <= 3'b000;
          if (w_mode) begin
            r_state     <= ST_SET_H;
            r_set_mode  <= 1'b1;
            r_presc     <= '0;
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
          end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
          end
        end
        default: begin
          if (w_mode) begin
            r_state    <= ST_RUN;
            r_set_mode <= 1'b0;
            r_presc    <= '0;
            r_blank    <= 3'b000;
          end else if (w_next || w_up) begin
            // Restart the blink on any edit so the touched field is visible immediately.
            if (w_next) r_state <= next_field(r_state);
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
            r_blank     <= 3'b000;
          end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_phase_on  <= ~r_phase_on;
            r_blank     <= r_phase_on ? field_mask(r_state) : 3'b000;
          end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign SET_MODE  = r_set_mode;
  assign SEL_FIELD = r_state;
  assign BLANK_H   = r_blank[2];
  assign BLANK_M   = r_blank[1];
  assign BLANK_S   = r_blank[0];
  assign SEC_PULSE = r_sec_pulse;

endmodule

// File: tb/tb_watch_time_ctrl.sv
// Bench for watch_time_ctrl: directed scenarios then random buttons, every cycle compared with a
// seconds-of-day reference model.
module tb_watch_time_ctrl;

  localparam int TPS = 4;
  localparam int BLK = 2;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       BTN_MODE = 1'b0, BTN_NEXT = 1'b0, BTN_UP = 1'b0;
  logic [3:0] H10, H1, M10, M1, S10, S1;
  logic       SET_MODE, BLANK_H, BLANK_M, BLANK_S, SEC_PULSE;
  logic [1:0] SEL_FIELD;

  watch_time_ctrl #(.TICKS_PER_SEC(TPS), .BLINK_TICKS(BLK)) dut (
    .CLK(CLK), .RESETN(RESETN), .BTN_MODE(BTN_MODE), .BTN_NEXT(BTN_NEXT), .BTN_UP(BTN_UP),
    .H10(H10), .H1(H1), .M10(M10), .M1(M1), .S10(S10), .S1(S1),
    .SET_MODE(SET_MODE), .SEL_FIELD(SEL_FIELD),
    .BLANK_H(BLANK_H), .BLANK_M(BLANK_M), .BLANK_S(BLANK_S), .SEC_PULSE(SEC_PULSE)
  );

  always #5 CLK = ~CLK;

  wire logic [23:0] w_time  = {H10, H1, M10, M1, S10, S1};
  wire logic [7:0]  w_flags = {SET_MODE, SEL_FIELD, BLANK_H, BLANK_M, BLANK_S, SEC_PULSE};

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: time as seconds of day, field 0=run 1=h 2=m 3=s, cycles since blink restart.
  int m_t = 0, m_field = 0, m_presc = 0, m_since = 0;
  bit m_pulse = 1'b0, m_pm = 1'b0, m_pn = 1'b0, m_pu = 1'b0;

  function automatic logic [7:0] bcd2(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic logic [23:0] exp_time();
    return {bcd2(m_t / 3600), bcd2((m_t / 60) % 60), bcd2(m_t % 60)};
  endfunction

  function automatic logic [7:0] exp_flags();
    logic off;
    off = (m_field != 0) && (((m_since / BLK) % 2) == 1);
    return {m_field != 0, 2'(m_field), off && (m_field == 1), off && (m_field == 2),
            off && (m_field == 3), m_pulse};
  endfunction

  function automatic int cur_field_val();
    case (m_field)
      1:       return m_t / 3600;
      2:       return (m_t / 60) % 60;
      default: return m_t % 60;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit bm, input bit bn, input bit bu);
    bit em, en, eu, a_mode, a_next, a_up;
    int h, mi, s;
    if (rst) begin
      m_t = 0; m_field = 0; m_presc = 0; m_since = 0;
      m_pulse = 0; m_pm = 0; m_pn = 0; m_pu = 0;
    end else begin
      em = bm && !m_pm;
      en = bn && !m_pn;
      eu = bu && !m_pu;
      a_mode = em;
      a_next = en && !em;
      a_up   = eu && !em && !en;
      if (m_field == 0) begin
        m_pulse = (m_presc == TPS - 1);
        if (m_pulse) m_t = (m_t + 1) % 86400;
        m_presc = m_pulse ? 0 : m_presc + 1;
        if (a_mode) begin
          m_field = 1; m_presc = 0; m_since = 0;
        end
      end else begin
        m_pulse = 0;
        if (a_mode) begin
          m_field = 0; m_presc = 0;
        end else if (a_next) begin
          m_field = (m_field == 3) ? 1 : m_field + 1;
          m_since = 0;
        end else if (a_up) begin
          h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
          case (m_field)
            1:       h  = (h + 1) % 24;
            2:       mi = (mi + 1) % 60;
            default: s  = (s + 1) % 60;
          endcase
          m_t = h * 3600 + mi * 60 + s;
          m_since = 0;
        end else begin
          m_since++;
        end
      end
      m_pm = bm; m_pn = bn; m_pu = bu;
    end
  endtask

  // One clock: drive on the falling edge, step the model on the rising edge, sample 1 ns later.
  task automatic cyc(input bit rst, input bit bm, input bit bn, input bit bu);
    @(negedge CLK);
    RESETN = ~rst; BTN_MODE = bm; BTN_NEXT = bn; BTN_UP = bu;
    @(posedge CLK);
    model_step(rst, bm, bn, bu);
    #1;
    check("time", 32'(w_time), 32'(exp_time()));
    check("flags", 32'(w_flags), 32'(exp_flags()));
  endtask

  task automatic press(input bit bm, input bit bn, input bit bu);
    cyc(1'b0, bm, bn, bu);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_up_to(input int target);
    for (int i = 0; i < 100 && cur_field_val() != target; i++) press(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses, wide;
    logic prev_pulse;

    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_time", 32'(w_time), 32'h0);
    check("rst_flags", 32'(w_flags), 32'h0);

    pulses = 0; wide = 0; prev_pulse = 1'b0;
    for (int i = 0; i < 4 * 60; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      if (SEC_PULSE) pulses++;
      if (SEC_PULSE && prev_pulse) wide++;
      prev_pulse = SEC_PULSE;
    end
    check("pulse_count", 32'(pulses), 32'd60);
    check("pulse_wide", 32'(wide), 32'd0);
    check("run_1min", 32'(w_time), 32'h000100);

    press(1'b1, 1'b0, 1'b0);
    press_up_to(23);
    press(1'b0, 1'b1, 1'b0);
    press_up_to(59);
    press(1'b0, 1'b1, 1'b0);
    press_up_to(59);
    check("preload", 32'(w_time), 32'h235959);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("run_entry", 32'(w_flags), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("hold_before_tick", 32'(w_time), 32'h235959);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("day_wrap", 32'(w_time), 32'h000000);
    check("day_wrap_pulse", 32'(SEC_PULSE), 32'd1);

    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press_up_to(59);
    check("m_at_59", 32'(w_time), 32'h005900);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("m_wrap_no_carry", 32'(w_time), 32'h000000);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("up_held_once", 32'(w_time), 32'h000000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    press(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("simul_mode_sel", 32'({SET_MODE, SEL_FIELD}), 32'b101);
    check("simul_time", 32'(w_time), 32'h000000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("blink_off", 32'({BLANK_H, BLANK_M, BLANK_S}), 32'b001);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("blink_on", 32'({BLANK_H, BLANK_M, BLANK_S}), 32'b000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("blink_off_again", 32'({BLANK_H, BLANK_M, BLANK_S}), 32'b001);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("up_unblank", 32'({BLANK_H, BLANK_M, BLANK_S}), 32'b000);
    check("up_sec", 32'({S10, S1}), 32'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    press_up_to(56);
    press(1'b0, 1'b1, 1'b0);
    press_up_to(12);
    press(1'b0, 1'b1, 1'b0);
    press_up_to(34);
    check("pre_reset_time", 32'(w_time), 32'h123456);
    check("pre_reset_sel", 32'(SEL_FIELD), 32'd2);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("mid_reset_time", 32'(w_time), 32'h000000);
    check("mid_reset_flags", 32'(w_flags), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
